regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- 8-entry register file built from per-register storage with a one-hot write decoder, two read ports and a per-register busy scoreboard.
- Sits directly downstream of the single-register cell. It instantiates WIDTH-bit storage per entry and drives each entry's data, clock and clear from the decoder.
- Consumers are the datapath read stage and the issue logic, which polls the busy flags.

Parameters:
- WIDTH, 8, data width of each register.
- NREG, 8, number of registers; must be a power of two.
- AW, 3, address width; must equal log2(NREG).

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- CLR  in  1  synchronous active-high reset.
- WE  in  1  write enable.
- WA  in  AW  write address.
- WD  in  WIDTH  write data.
- RSV  in  1  reserve request: mark register RSVA busy (pending write).
- RSVA  in  AW  reserve address.
- RA1  in  AW  read address, port 1.
- RA2  in  AW  read address, port 2.
- RD1  out  WIDTH  read data, port 1.
- RD2  out  WIDTH  read data, port 2.
- BSY1  out  1  busy flag of register RA1.
- BSY2  out  1  busy flag of register RA2.
- BUSYV  out  NREG  full busy vector; bit i = register i busy.

Behaviour:
- Reset:
  - CLR is sampled only on the rising edge of Clk; there is no asynchronous path.
  - With CLR=1 at an edge, every register becomes 0 and every busy bit becomes 0, regardless of WE/RSV in that cycle.
  - After that edge RD1=RD2=0, BSY1=BSY2=0, BUSYV=0.
  - CLR asserted mid-sequence discards any pending reservation; it takes effect on the next edge.
- Register 0:
  - Reads as 0 on both ports.
  - Writes to WA=0 are ignored.
  - RSV with RSVA=0 is ignored, so BUSYV[0] is always 0.
- Write decoder:
  - One-hot enable: en[i] = WE & (WA==i) & (i!=0).
  - Exactly one register updates per edge with WE=1 and WA!=0; all others hold.
  - The write lands on the rising edge, so latency is 1 cycle.
- Read ports:
  - Combinational: RDn = reg[RAn].
  - Write-first bypass: if WE=1, WA==RAn and WA!=0 in the same cycle, RDn = WD (same-cycle forwarding).
  - Both ports may address the same register; they return identical data.
- Scoreboard:
  - At a rising edge, RSV=1 (RSVA!=0) sets busy[RSVA].
  - At a rising edge, WE=1 (WA!=0) clears busy[WA].
  - Simultaneous RSV and WE to the same address: the set wins. busy stays 1 and data is written; this models back-to-back writers.
  - Simultaneous RSV and WE to different addresses: both take effect.
  - Reserving an already-busy register keeps it busy (no count; single bit).
  - A write to a non-busy register is legal; busy stays 0.
- Busy outputs:
  - BSYn = busy[RAn], from registered state only. There is no bypass of a same-cycle clear: BSYn still reads 1 during the cycle the clearing write is presented.
  - BUSYV is the registered busy vector.
- No X propagation: every register and busy bit has a defined value after the first CLR edge.

Test Plan:
- Reset: preload WD=8'hFF into regs 1..7, then CLR=1 for one edge with WE=1, WA=3, WD=8'hAA -> all RD=0, BUSYV=8'h00 after the edge; reg3 is not written.
- Write/read: WE=1, WA=5, WD=8'h3C at edge -> next cycle RA1=5 gives RD1=8'h3C. Same cycle as the write, RA2=5 gives RD2=8'h3C via bypass. RA1=4 is unchanged.
- Register 0: WE=1, WA=0, WD=8'h77 and RSV=1, RSVA=0 -> RD1(RA1=0)=0, BUSYV[0]=0.
- Scoreboard: RSV, RSVA=2 at edge -> BUSYV=8'h04 and BSY1=1 with RA1=2. Then WE, WA=2, WD=8'h11 -> BUSYV=8'h00 next cycle and RD1=8'h11.
- Collision: busy[6]=1, then same edge RSV, RSVA=6 and WE, WA=6, WD=8'h5A -> BUSYV[6]=1, reg6=8'h5A. Also same edge RSV, RSVA=1 and WE, WA=6 -> BUSYV bit1 set, bit6 cleared.
- Mid-operation reset: reserve regs 1, 3, 7 (BUSYV=8'h8A), then CLR=1 with RSV, RSVA=4 -> BUSYV=8'h00 and all registers 0.

Source files
------------

// File: rtl/regfile_sb.sv
// Eight-entry register file: per-entry storage cells behind a one-hot write decoder,
// two combinational read ports with write-first forwarding, and a busy scoreboard.

module regfile_sb_cell #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             clr_i,
   input  logic             en_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] data_q;

   // Storage element: clear dominates, otherwise load on enable, otherwise hold.
   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         data_q <= {WIDTH{1'b0}};
      end else if (en_i) begin
         data_q <= d_i;
      end else begin
         data_q <= data_q;
      end
   end

   assign q_o = data_q;

endmodule

module regfile_sb #(
   parameter int WIDTH = 8,
   parameter int NREG  = 8,
   parameter int AW    = 3
) (
   input  logic             Clk,
   input  logic             CLR,
   input  logic             WE,
   input  logic [AW-1:0]    WA,
   input  logic [WIDTH-1:0] WD,
   input  logic             RSV,
   input  logic [AW-1:0]    RSVA,
   input  logic [AW-1:0]    RA1,
   input  logic [AW-1:0]    RA2,
   output logic [WIDTH-1:0] RD1,
   output logic [WIDTH-1:0] RD2,
   output logic             BSY1,
   output logic             BSY2,
   output logic [NREG-1:0]  BUSYV
);

   logic [NREG-1:0]             en_s;
   logic [NREG-1:0][WIDTH-1:0]  regs_s;
   logic [NREG-1:0]             busy_d;
   logic [NREG-1:0]             busy_q;
   logic                        wa_nz_s;
   logic                        rsva_nz_s;

   assign wa_nz_s   = (WA != {AW{1'b0}});
   assign rsva_nz_s = (RSVA != {AW{1'b0}});

   // One-hot write decoder; entry 0 never receives an enable so it stays at zero.
   always_comb begin
      en_s = {NREG{1'b0}};
      for (int i = 0; i < NREG; i++) begin
         if (WE && wa_nz_s && (WA == AW'(i))) begin
            en_s[i] = 1'b1;
         end else begin
            en_s[i] = 1'b0;
         end
      end
   end

   for (genvar g = 0; g < NREG; g++) begin : g_cell
      regfile_sb_cell #(.WIDTH(WIDTH)) u_cell (
         .clk_i (Clk),
         .clr_i (CLR),
         .en_i  (en_s[g]),
         .d_i   (WD),
         .q_o   (regs_s[g])
      );
   end

   // Read port 1 with same-cycle write forwarding.
   always_comb begin
      if (WE && wa_nz_s && (WA == RA1)) begin
         RD1 = WD;
      end else begin
         RD1 = regs_s[RA1];
      end
   end

   // Read port 2 with same-cycle write forwarding.
   always_comb begin
      if (WE && wa_nz_s && (WA == RA2)) begin
         RD2 = WD;
      end else begin
         RD2 = regs_s[RA2];
      end
   end

   // Scoreboard next state: a reservation beats a completing write to the same entry.
   always_comb begin
      busy_d = busy_q;
      for (int i = 0; i < NREG; i++) begin
         if (CLR) begin
            busy_d[i] = 1'b0;
         end else if (RSV && rsva_nz_s && (RSVA == AW'(i))) begin
            busy_d[i] = 1'b1;
         end else if (en_s[i]) begin
            busy_d[i] = 1'b0;
         end else begin
            busy_d[i] = busy_q[i];
         end
      end
   end

   // Scoreboard state register.
   always_ff @(posedge Clk) begin
      busy_q <= busy_d;
   end

   // Busy flags come from registered state only; a same-cycle clear is not forwarded.
   assign BSY1  = busy_q[RA1];
   assign BSY2  = busy_q[RA2];
   assign BUSYV = busy_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a directed vector table followed by randomized traffic
// checked against an array-based model of the register file and scoreboard.

module tb_regfile_sb;

   logic       Clk;
   logic       CLR;
   logic       WE;
   logic [2:0] WA;
   logic [7:0] WD;
   logic       RSV;
   logic [2:0] RSVA;
   logic [2:0] RA1;
   logic [2:0] RA2;
   logic [7:0] RD1;
   logic [7:0] RD2;
   logic       BSY1;
   logic       BSY2;
   logic [7:0] BUSYV;

   int tests_run;
   int tests_failed;

   regfile_sb #(.WIDTH(8), .NREG(8), .AW(3)) dut (
      .Clk   (Clk),
      .CLR   (CLR),
      .WE    (WE),
      .WA    (WA),
      .WD    (WD),
      .RSV   (RSV),
      .RSVA  (RSVA),
      .RA1   (RA1),
      .RA2   (RA2),
      .RD1   (RD1),
      .RD2   (RD2),
      .BSY1  (BSY1),
      .BSY2  (BSY2),
      .BUSYV (BUSYV)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      logic       clr;
      logic       we;
      logic [2:0] wa;
      logic [7:0] wd;
      logic       rsv;
      logic [2:0] rsva;
      logic [2:0] ra1;
      logic [2:0] ra2;
      logic [7:0] rd1;
      logic [7:0] rd2;
      logic       b1;
      logic       b2;
      logic [7:0] bv;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(logic clr, logic we, logic [2:0] wa, logic [7:0] wd,
                              logic rsv, logic [2:0] rsva, logic [2:0] ra1, logic [2:0] ra2,
                              logic [7:0] rd1, logic [7:0] rd2, logic b1, logic b2,
                              logic [7:0] bv);
      vec_t r;
      r.clr = clr; r.we = we; r.wa = wa; r.wd = wd; r.rsv = rsv; r.rsva = rsva;
      r.ra1 = ra1; r.ra2 = ra2; r.rd1 = rd1; r.rd2 = rd2; r.b1 = b1; r.b2 = b2; r.bv = bv;
      return r;
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic drive(input logic clr, input logic we, input logic [2:0] wa,
                        input logic [7:0] wd, input logic rsv, input logic [2:0] rsva,
                        input logic [2:0] ra1, input logic [2:0] ra2);
      @(negedge Clk);
      CLR = clr; WE = we; WA = wa; WD = wd; RSV = rsv; RSVA = rsva; RA1 = ra1; RA2 = ra2;
      #1;
   endtask

   logic [7:0] m_reg  [8];
   logic       m_busy [8];

   initial begin
      logic [7:0] e_rd1, e_rd2, e_bv;
      logic       r_clr, r_we, r_rsv;
      logic [2:0] r_wa, r_rsva, r_ra1, r_ra2;
      logic [7:0] r_wd;
      vec_t t;

      tests_run = 0;
      tests_failed = 0;
      CLR = 1'b1; WE = 1'b0; WA = 3'd0; WD = 8'h00; RSV = 1'b0; RSVA = 3'd0;
      RA1 = 3'd0; RA2 = 3'd0;

      // Initial reset edge, then the directed table
      drive(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 3'd0);

      for (int i = 1; i < 8; i++)
         tbl.push_back(v(1'b0, 1'b1, 3'(i), 8'hFF, 1'b0, 3'd0, 3'(i), 3'd0, 8'hFF, 8'h00, 1'b0, 1'b0, 8'h00));
      tbl.push_back(v(0, 0, 3'd0, 8'h00, 0, 3'd0, 3'd7, 3'd1, 8'hFF, 8'hFF, 0, 0, 8'h00));
      // Reset wins over a concurrent write to reg3
      tbl.push_back(v(1, 1, 3'd3, 8'hAA, 0, 3'd0, 3'd2, 3'd5, 8'hFF, 8'hFF, 0, 0, 8'h00));
      tbl.push_back(v(0, 0, 3'd0, 8'h00, 0, 3'd0, 3'd3, 3'd5, 8'h00, 8'h00, 0, 0, 8'h00));
      tbl.push_back(v(0, 1, 3'd5, 8'h3C, 0, 3'd0, 3'd4, 3'd5, 8'h00, 8'h3C, 0, 0, 8'h00));
      tbl.push_back(v(0, 0, 3'd0, 8'h00, 0, 3'd0, 3'd5, 3'd4, 8'h3C, 8'h00, 0, 0, 8'h00));
      // Register 0 ignores write and reserve
      tbl.push_back(v(0, 1, 3'd0, 8'h77, 1, 3'd0, 3'd0, 3'd0, 8'h00, 8'h00, 0, 0, 8'h00));
      tbl.push_back(v(0, 0, 3'd0, 8'h00, 0, 3'd0, 3'd0, 3'd5, 8'h00, 8'h3C, 0, 0, 8'h00));
      tbl.push_back(v(0, 0, 3'd0, 8'h00, 1, 3'd2, 3'd2, 3'd2, 8'h00, 8'h00, 0, 0, 8'h00));
      // Busy flag still 1 while its clearing write is presented
      tbl.push_back(v(0, 1, 3'd2, 8'h11, 0, 3'd0, 3'd2, 3'd3, 8'h11, 8'h00, 1, 0, 8'h04));
      tbl.push_back(v(0, 0, 3'd0, 8'h00, 0, 3'd0, 3'd2, 3'd2, 8'h11, 8'h11, 0, 0, 8'h00));
      tbl.push_back(v(0, 0, 3'd0, 8'h00, 1, 3'd6, 3'd6, 3'd0, 8'h00, 8'h00, 0, 0, 8'h00));
      tbl.push_back(v(0, 1, 3'd6, 8'h5A, 1, 3'd6, 3'd6, 3'd6, 8'h5A, 8'h5A, 1, 1, 8'h40));
      tbl.push_back(v(0, 0, 3'd0, 8'h00, 0, 3'd0, 3'd6, 3'd0, 8'h5A, 8'h00, 1, 0, 8'h40));
      tbl.push_back(v(0, 1, 3'd6, 8'h22, 1, 3'd1, 3'd6, 3'd1, 8'h22, 8'h00, 1, 0, 8'h40));
      tbl.push_back(v(0, 0, 3'd0, 8'h00, 1, 3'd1, 3'd6, 3'd1, 8'h22, 8'h00, 0, 1, 8'h02));
      tbl.push_back(v(0, 0, 3'd0, 8'h00, 1, 3'd3, 3'd0, 3'd0, 8'h00, 8'h00, 0, 0, 8'h02));
      tbl.push_back(v(0, 0, 3'd0, 8'h00, 1, 3'd7, 3'd0, 3'd0, 8'h00, 8'h00, 0, 0, 8'h0A));
      // Reset discards a concurrent reservation
      tbl.push_back(v(1, 0, 3'd0, 8'h00, 1, 3'd4, 3'd6, 3'd7, 8'h22, 8'h00, 0, 1, 8'h8A));
      tbl.push_back(v(0, 0, 3'd0, 8'h00, 0, 3'd0, 3'd6, 3'd4, 8'h00, 8'h00, 0, 0, 8'h00));

      foreach (tbl[k]) begin
         t = tbl[k];
         drive(t.clr, t.we, t.wa, t.wd, t.rsv, t.rsva, t.ra1, t.ra2);
         chk($sformatf("vec%0d RD1", k), RD1, t.rd1);
         chk($sformatf("vec%0d RD2", k), RD2, t.rd2);
         chk($sformatf("vec%0d BSY1", k), {7'd0, BSY1}, {7'd0, t.b1});
         chk($sformatf("vec%0d BSY2", k), {7'd0, BSY2}, {7'd0, t.b2});
         chk($sformatf("vec%0d BUSYV", k), BUSYV, t.bv);
      end

      // Randomized phase: model starts from a reset edge
      drive(1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 3'd0, 3'd0);
      for (int i = 0; i < 8; i++) begin
         m_reg[i] = 8'h00;
         m_busy[i] = 1'b0;
      end

      for (int n = 0; n < 600; n++) begin
         r_clr  = ($urandom_range(0, 39) == 0);
         r_we   = $urandom_range(0, 1);
         r_wa   = 3'($urandom_range(0, 7));
         r_wd   = 8'($urandom);
         r_rsv  = $urandom_range(0, 1);
         r_rsva = ($urandom_range(0, 3) == 0) ? r_wa : 3'($urandom_range(0, 7));
         r_ra1  = ($urandom_range(0, 2) == 0) ? r_wa : 3'($urandom_range(0, 7));
         r_ra2  = ($urandom_range(0, 3) == 0) ? r_ra1 : 3'($urandom_range(0, 7));
         drive(r_clr, r_we, r_wa, r_wd, r_rsv, r_rsva, r_ra1, r_ra2);

         e_rd1 = (r_we && r_wa != 3'd0 && r_wa == r_ra1) ? r_wd : m_reg[r_ra1];
         e_rd2 = (r_we && r_wa != 3'd0 && r_wa == r_ra2) ? r_wd : m_reg[r_ra2];
         for (int i = 0; i < 8; i++) e_bv[i] = m_busy[i];
         chk("rand RD1", RD1, e_rd1);
         chk("rand RD2", RD2, e_rd2);
         chk("rand BSY1", {7'd0, BSY1}, {7'd0, m_busy[r_ra1]});
         chk("rand BSY2", {7'd0, BSY2}, {7'd0, m_busy[r_ra2]});
         chk("rand BUSYV", BUSYV, e_bv);

         if (r_clr) begin
            for (int i = 0; i < 8; i++) begin
               m_reg[i] = 8'h00;
               m_busy[i] = 1'b0;
            end
         end else begin
            if (r_we && r_wa != 3'd0) begin
               m_reg[r_wa] = r_wd;
               m_busy[r_wa] = 1'b0;
            end
            if (r_rsv && r_rsva != 3'd0) m_busy[r_rsva] = 1'b1;
         end
      end

      @(negedge Clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
